// File: rtl/bpsk_pkg.sv
// Shared FSM state type, sine LUT geometry and quarter-wave table helper
// for the BPSK transmitter.
package bpsk_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

    localparam int LUT_DEPTH   = 1024;
    localparam int LUT_AW      = 10;
    localparam int QTR_ENTRIES = 257;
    localparam int QTR_AW      = 9;
    localparam int DEFAULT_AMP = 2047;

    localparam real PI = 3.14159265358979323846;

    // round(amp * sin(2*pi*k/LUT_DEPTH)) for 0 <= k <= LUT_DEPTH/4, via a
    // Taylor series so the table folds to constants without a math library.
    function automatic int quarter_sine(input int k, input int amp);
        real x;
        real term;
        real sum;
        x    = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
        term = x;
        sum  = x;
        for (int unsigned n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(amp) * sum + 0.5);
    endfunction

endpackage

// File: rtl/bpsk_tx_if.sv
// Byte-in / sample-out bundle of the BPSK transmitter.
interface bpsk_tx_if #(
    parameter int FTW_W = 32,
    parameter int OUT_W = 12
);
    logic [FTW_W-1:0]        ftw;
    logic [7:0]              din;
    logic                    din_valid;
    logic                    din_ready;
    logic signed [OUT_W-1:0] sigout;
    logic                    busy;

    modport master (
        output ftw, din, din_valid,
        input  din_ready, sigout, busy
    );

    modport slave (
        input  ftw, din, din_valid,
        output din_ready, sigout, busy
    );
endinterface

// File: rtl/bpsk_tx_sine_lut.sv
// Quarter-wave sine table with quadrant mirroring/negation and one output
// register: 10-bit phase address in, signed OUT_W sample out one cycle later.
module sine_lut
    import bpsk_pkg::*;
#(
    parameter int OUT_W = 12,
    parameter int AMP   = DEFAULT_AMP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LUT_AW-1:0]       addr,
    output logic signed [OUT_W-1:0] sine
);

    logic signed [OUT_W-1:0] qtr [QTR_ENTRIES];

    for (genvar k = 0; k < QTR_ENTRIES; k++) begin : g_qtr
        localparam int VAL = quarter_sine(k, AMP);
        assign qtr[k] = OUT_W'(VAL);
    end

    logic [1:0]              quad;
    logic [7:0]              off;
    logic [QTR_AW-1:0]       idx;
    logic signed [OUT_W-1:0] mag;
    logic signed [OUT_W-1:0] val;

    // Odd quadrants read the table backwards; the lower half-cycle is negated.
    always_comb begin
        quad = addr[LUT_AW-1 -: 2];
        off  = addr[7:0];
        idx  = quad[0] ? (QTR_AW'(QTR_ENTRIES - 1) - QTR_AW'(off)) : QTR_AW'(off);
        mag  = qtr[idx];
        val  = quad[1] ? -mag : mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sine <= '0;
        end else begin
            sine <= val;
        end
    end

endmodule

// File: rtl/bpsk_tx.sv
// BPSK transmitter: bytes MSB first, SPS samples per bit, DDS carrier.
// Define BPSK_TX_DIFF_ENC_EN for differential encoding of transmitted bits.
module bpsk_tx
    import bpsk_pkg::*;
#(
    parameter int SPS   = 100,
    parameter int FTW_W = 32,
    parameter int OUT_W = 12,
    parameter int AMP   = DEFAULT_AMP
) (
    input  logic      CLK_IN,
    input  logic      RESET,
    bpsk_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(SPS);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [2:0]              bit_idx, bit_idx_n;
    logic [7:0]              shreg, shreg_n;
    logic [FTW_W-1:0]        phase;
    logic                    bit_end;
    logic                    xfer;
    logic                    data_bit;
    logic                    tx_bit;
    logic                    act_d;
    logic                    bit_d;
    logic signed [OUT_W-1:0] lut_q;

    assign bit_end = (cnt == CNT_W'(SPS - 1));
    assign xfer    = bus.din_valid && bus.din_ready;

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_n   = SEND;
                    cnt_n     = '0;
                    bit_idx_n = 3'd7;
                    shreg_n   = bus.din;
                end
            end
            SEND: begin
                if (!bit_end) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (bit_idx != 3'd0) begin
                        bit_idx_n = bit_idx - 3'd1;
                    end else if (xfer) begin
                        bit_idx_n = 3'd7;
                        shreg_n   = bus.din;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Ready is held low through reset so no byte is taken on a reset edge.
    always_comb begin
        bus.din_ready = 1'b0;
        if (!RESET) begin
            unique case (state)
                IDLE:    bus.din_ready = 1'b1;
                SEND:    bus.din_ready = bit_end && (bit_idx == 3'd0);
                default: bus.din_ready = 1'b0;
            endcase
        end
        data_bit = shreg[bit_idx];
    end

`ifdef BPSK_TX_DIFF_ENC_EN
    logic ref_bit;

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            ref_bit <= 1'b0;
        end else if (state == SEND && bit_end) begin
            ref_bit <= tx_bit;
        end
    end

    assign tx_bit = data_bit ^ ref_bit;
`else
    assign tx_bit = data_bit;
`endif

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            phase <= '0;
        end else begin
            phase <= phase + bus.ftw;
        end
    end

    sine_lut #(
        .OUT_W (OUT_W),
        .AMP   (AMP)
    ) u_lut (
        .clk  (CLK_IN),
        .rst  (RESET),
        .addr (phase[FTW_W-1 -: LUT_AW]),
        .sine (lut_q)
    );

    // The symbol flag takes one register here and the sigout register is the
    // second, matching the LUT's two-cycle path from phase to output.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            act_d      <= 1'b0;
            bit_d      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.sigout <= '0;
        end else begin
            act_d      <= (state == SEND);
            bit_d      <= tx_bit;
            bus.busy   <= act_d;
            bus.sigout <= !act_d ? '0 : (bit_d ? lut_q : -lut_q);
        end
    end

endmodule

// File: tb/tb_bpsk_tx.sv
// Self-checking bench for bpsk_tx (SPS=4); honours BPSK_TX_DIFF_ENC_EN.
module tb_bpsk_tx;

    localparam int          SPS   = 4;
    localparam int          FTW_W = 32;
    localparam int          OUT_W = 12;
    localparam int          AMP   = 2047;
    localparam logic [31:0] F30   = 32'h4000_0000;
    localparam logic [31:0] F29   = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpsk_tx_if #(.FTW_W(FTW_W), .OUT_W(OUT_W)) bus ();

    bpsk_tx #(
        .SPS   (SPS),
        .FTW_W (FTW_W),
        .OUT_W (OUT_W),
        .AMP   (AMP)
    ) dut (
        .CLK_IN (clk),
        .RESET  (rst),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    function automatic int sine_ref(input int addr);
        real s;
        s = real'(AMP) * $sin(2.0 * 3.14159265358979 * real'(addr) / 1024.0);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    endfunction

    // Model state describes the current cycle; advanced once per negedge.
    bit          m_valid = 0;
    logic [31:0] m_phase;
    bit          m_send;
    int          m_pos;
    logic [7:0]  m_byte;
`ifdef BPSK_TX_DIFF_ENC_EN
    bit          m_ref;
`endif
    int          d1_sig, e_sig;
    bit          d1_act, e_busy;
    bit          ready_m, xfer_m, tx_m;
    int          ideal;

    bit          collect = 0;
    int          samples[$];
    int          busy_run = 0;
    int          max_run = 0;

    initial begin
        forever begin
            @(negedge clk);
            ready_m = !rst && (!m_send || m_pos == 8 * SPS - 1);
            if (m_valid) begin
                chk("sigout", int'(bus.sigout), e_sig);
                chk("busy", int'(bus.busy), int'(e_busy));
                chk("din_ready", int'(bus.din_ready), int'(ready_m));
                busy_run = bus.busy ? busy_run + 1 : 0;
                if (busy_run > max_run) max_run = busy_run;
                if (collect && bus.busy) samples.push_back(int'(bus.sigout));
            end
            xfer_m = bus.din_valid && ready_m;
            tx_m   = m_byte[7 - m_pos / SPS];
`ifdef BPSK_TX_DIFF_ENC_EN
            tx_m   = tx_m ^ m_ref;
`endif
            ideal  = !m_send ? 0 : (tx_m ? sine_ref(int'(m_phase[31:22]))
                                         : -sine_ref(int'(m_phase[31:22])));
            if (rst) begin
                m_valid = 1;
                m_phase = '0;
                m_send  = 0;
                m_pos   = 0;
                m_byte  = '0;
`ifdef BPSK_TX_DIFF_ENC_EN
                m_ref   = 0;
`endif
                d1_sig  = 0;
                d1_act  = 0;
                e_sig   = 0;
                e_busy  = 0;
            end else begin
                e_sig   = d1_sig;
                e_busy  = d1_act;
                d1_sig  = ideal;
                d1_act  = m_send;
                m_phase = m_phase + bus.ftw;
`ifdef BPSK_TX_DIFF_ENC_EN
                if (m_send && (m_pos % SPS == SPS - 1)) m_ref = tx_m;
`endif
                if (m_send) begin
                    if (m_pos == 8 * SPS - 1) begin
                        if (xfer_m) begin
                            m_byte = bus.din;
                            m_pos  = 0;
                        end else begin
                            m_send = 0;
                        end
                    end else begin
                        m_pos++;
                    end
                end else if (xfer_m) begin
                    m_send = 1;
                    m_pos  = 0;
                    m_byte = bus.din;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_0x80(input int i);
        int p;
        int sgn;
        case (i % 4)
            1:       p = 2047;
            3:       p = -2047;
            default: p = 0;
        endcase
`ifdef BPSK_TX_DIFF_ENC_EN
        sgn = 1;
`else
        sgn = (i < 4) ? 1 : -1;
`endif
        return sgn * p;
    endfunction

    function automatic int exp_0xff(input int g);
`ifdef BPSK_TX_DIFF_ENC_EN
        return (g % 2 == 0) ? 2047 : -2047;
`else
        return 2047 + 0 * g;
`endif
    endfunction

    initial begin
        bus.ftw       = F30;
        bus.din       = '0;
        bus.din_valid = 1'b0;

        chk("model_s0", sine_ref(0), 0);
        chk("model_s128", sine_ref(128), 1447);
        chk("model_s256", sine_ref(256), 2047);
        chk("model_s768", sine_ref(768), -2047);

        // Idle after reset, then one byte aligned so SEND starts at phase 0.
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_first_cycle", int'(bus.din_ready), 1);
        chk("busy_first_cycle", int'(bus.busy), 0);
        repeat (11) step();
        bus.din_valid = 1'b1;
        bus.din       = 8'h80;
        samples.delete();
        collect = 1;
        step();
        bus.din_valid = 1'b0;
        repeat (40) step();
        collect = 0;
        chk("n_samples_0x80", samples.size(), 32);
        for (int i = 0; i < samples.size() && i < 32; i++)
            chk("sample_0x80", samples[i], exp_0x80(i));

        // Back-to-back bytes with din_valid held.
        max_run       = 0;
        bus.din_valid = 1'b1;
        bus.din       = 8'hA5;
        step();
        bus.din       = 8'h3C;
        repeat (32) step();
        bus.din_valid = 1'b0;
        repeat (72) step();
        chk("busy_run", max_run, 16 * SPS);

        // Tuning word halved mid-symbol.
        bus.din_valid = 1'b1;
        bus.din       = 8'h5A;
        step();
        bus.din_valid = 1'b0;
        repeat (6) step();
        bus.ftw = F29;
        repeat (40) step();

        // One-cycle reset in the middle of a byte.
        bus.ftw       = F30;
        bus.din_valid = 1'b1;
        bus.din       = 8'hC3;
        step();
        bus.din_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", int'(bus.din_ready), 1);
        chk("busy_after_midreset", int'(bus.busy), 0);
        chk("sigout_after_midreset", int'(bus.sigout), 0);

        // 0xFF from a freshly reset reference bit, aligned to phase 0.
        repeat (3) step();
        bus.din_valid = 1'b1;
        bus.din       = 8'hFF;
        samples.delete();
        collect = 1;
        step();
        bus.din_valid = 1'b0;
        repeat (40) step();
        collect = 0;
        chk("n_samples_0xff", samples.size(), 32);
        for (int g = 0; g < 8 && (4 * g + 1) < samples.size(); g++)
            chk("sample_0xff", samples[4 * g + 1], exp_0xff(g));

        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bpsk_tx.md
BPSK_TX -- requirements
Module: bpsk_tx

Interface
REQ-001 Parameter SPS, default 100, samples per symbol (range 2..65535).
REQ-002 Parameter FTW_W, default 32, phase accumulator and tuning word width.
REQ-003 Parameter OUT_W, default 12, output sample width (signed).
REQ-004 Parameter AMP, default 2047, sine peak magnitude; AMP SHALL be no greater than 2^(OUT_W-1)-1.
REQ-005 CLK_IN  in  1  Sole clock, 100 MHz; every register is clocked by its rising edge.
REQ-006 RESET  in  1  Synchronous, active-high reset.
REQ-007 ftw  in  FTW_W  Carrier tuning word; sampled every cycle.
REQ-008 din  in  8  Data byte, transmitted MSB first.
REQ-009 din_valid  in  1  din is valid.
REQ-010 din_ready  out  1  Block accepts din this cycle.
REQ-011 sigout  out  OUT_W  Signed modulated sample (the sigin stream for the Costas receiver).
REQ-012 busy  out  1  A symbol is being transmitted.

Function
REQ-013 A byte SHALL be transferred on any rising edge where din_valid and din_ready are both 1.
REQ-014 FSM states: IDLE, SEND.
- IDLE: din_ready=1, busy=0; transfer -> SEND.
- SEND: 8 bits x SPS cycles per byte.
REQ-015 In SEND, din_ready SHALL be 1 only in the final cycle of bit 0. A transfer in that cycle SHALL start the next byte's MSB on the next cycle, with no gap; if there is no transfer, the FSM returns to IDLE.
REQ-016 A symbol counter SHALL run 0..SPS-1. The bit index SHALL advance when the counter wraps.
REQ-017 The phase accumulator SHALL add ftw every cycle in every state and wrap modulo 2^FTW_W. It is never cleared except by RESET.
REQ-018 Sine lookup address = top 10 bits of the phase (1024 points per cycle). The table is quarter-wave, 257 entries: entry k = round(AMP*sin(2*pi*k/1024)). The other quadrants are derived by mirroring and negation.
REQ-019 Pipeline: cycle t phase -> registered LUT output at t+1 -> registered sigout at t+2.
- sigout(t+2) = +sine if the bit active at t is 1.
- sigout(t+2) = -sine if the bit active at t is 0.
- sigout(t+2) = 0 if the FSM is IDLE at t.
- The bit/idle flag SHALL be delayed 2 cycles to stay aligned with the sine path.
REQ-020 Negation SHALL be exact two's complement. No saturation is needed because |sine| <= AMP.
REQ-021 busy SHALL be aligned with sigout: busy is 1 exactly on cycles where sigout carries a symbol sample.
REQ-022 A change of ftw mid-symbol SHALL take effect from the next accumulation, phase-continuously.

Reset
REQ-023 While RESET=1, at the clock edge: phase=0, FSM=IDLE, counters=0, pipeline=0, sigout=0, busy=0, din_ready=0.
REQ-024 din_ready SHALL become 1 on the first cycle after RESET deasserts.
REQ-025 RESET asserted mid-byte SHALL discard the byte. No partial symbol SHALL appear after the 2-cycle flush.

Configuration
REQ-026 Macro BPSK_TX_DIFF_ENC_EN, when defined, SHALL enable differential encoding.
- Transmitted bit = data bit XOR previous transmitted bit.
- The reference bit is reset to 0 and held across IDLE.
- This resolves Costas 180-degree ambiguity.
REQ-027 When the macro is undefined, the data bit SHALL be transmitted directly and no reference register SHALL exist.

Structure
REQ-028 Shared package bpsk_pkg SHALL hold: the FSM state enum, the LUT depth/address width constants (1024, 10, 257), and the default AMP.
REQ-029 Sub-module sine_lut SHALL contain the quarter-wave table, quadrant mapping and one output register. Its input is the 10-bit address; its output is the signed OUT_W value.

Verification
REQ-030 Reset, then ftw=2^30, no data: sigout=0 and busy=0 for all cycles; din_ready=1 from the first post-reset cycle.
REQ-031 ftw=2^30, SPS=4, byte 0x80 (DIFF off) -> first 4 symbol samples 0,2047,0,-2047; next 28 samples 0,-2047,0,2047 repeated; then sigout=0.
REQ-032 Two bytes offered back-to-back with din_valid held -> 16*SPS contiguous busy cycles, second transfer in the last cycle of the first byte, no zero gap.
REQ-033 BPSK_TX_DIFF_ENC_EN defined, byte 0xFF -> transmitted bits 1,0,1,0,1,0,1,0; sigout sign alternates every SPS samples.
REQ-034 RESET pulsed for 1 cycle at mid-byte -> sigout=0 two cycles later, FSM IDLE, din_ready=1 next cycle, phase restarts from 0.
REQ-035 ftw changed from 2^30 to 2^29 mid-symbol -> phase step halves on the following sample; no phase discontinuity beyond the new step.
